keypad_code_entry: RTL and testbench

- Keypad code-entry controller. It collects CODE_LEN decoded digit presses, compares them against a stored code, and reports unlock, error, timeout or lockout.
- It is the controlling end of the entry-window timer: it drives timer_en and consumes time_up to abort an entry that runs too long.
- Position: between the keypad scanner/debouncer (key_valid/key_code) and the lock/LED outputs.

---
 rtl/keypad_code_entry_if.sv | 23 ++
 rtl/keypad_code_entry.sv | 174 +++++++++++++++++
 tb/tb_keypad_code_entry.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_code_entry_if.sv
// Keypad-side signal bundle for the code-entry controller: key events and
// timer expiry in, timer enable and status flags out.
interface keypad_code_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       time_up;
  logic       timer_en;
  logic       unlock;
  logic       error;
  logic       timeout;
  logic       lockout;
  logic [2:0] digit_count;

  modport master (
    output key_valid, key_code, time_up,
    input  timer_en, unlock, error, timeout, lockout, digit_count
  );

  modport slave (
    input  key_valid, key_code, time_up,
    output timer_en, unlock, error, timeout, lockout, digit_count
  );
endinterface

// File: rtl/keypad_code_entry.sv
// Keypad code-entry controller: collects CODE_LEN digits, checks them against
// CODE, and reports unlock / error / timeout / lockout with registered outputs.
module keypad_code_entry #(
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [27:0] CODE           = 28'h1234,
  parameter int unsigned HOLD_CYCLES    = 100,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  keypad_code_entry_if.slave  kp_io
);

  localparam int unsigned BufW    = CODE_LEN * 4;
  localparam logic [2:0]  CntLen  = 3'(CODE_LEN);
  localparam logic [15:0] HoldEnd = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] LockEnd = 16'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StEntry, StCheck, StUnlock, StFail, StLockout
  } state_e;

  state_e            state_q, state_d;
  logic [BufW-1:0]   buf_q, buf_d;
  logic [2:0]        count_q, count_d;
  logic [2:0]        fails_q, fails_d;
  logic [15:0]       hold_q, hold_d;
  logic              timer_en_q, timer_en_d;
  logic              unlock_q, unlock_d;
  logic              error_q, error_d;
  logic              timeout_q, timeout_d;
  logic              lockout_q, lockout_d;

  logic              is_digit, is_clear;
  logic [BufW-1:0]   shifted;
  logic [2:0]        count_inc;

  always_comb begin
    is_digit  = kp_io.key_valid && (kp_io.key_code <= 4'd9);
    is_clear  = kp_io.key_valid && (kp_io.key_code == 4'hE);
    // Truncating cast drops the nibble shifted out past the buffer width.
    shifted   = BufW'({buf_q, kp_io.key_code});
    count_inc = count_q + 3'd1;

    state_d    = state_q;
    buf_d      = buf_q;
    count_d    = count_q;
    fails_d    = fails_q;
    hold_d     = hold_q;
    timer_en_d = timer_en_q;
    unlock_d   = unlock_q;
    error_d    = error_q;
    timeout_d  = 1'b0;
    lockout_d  = lockout_q;

    case (state_q)
      StIdle: begin
        if (is_digit) begin
          buf_d   = shifted;
          count_d = 3'd1;
          if (CntLen == 3'd1) begin
            state_d = StCheck;
          end else begin
            state_d    = StEntry;
            timer_en_d = 1'b1;
          end
        end
      end
      StEntry: begin
        if (kp_io.time_up || is_clear) begin
          state_d    = StIdle;
          buf_d      = '0;
          count_d    = 3'd0;
          timer_en_d = 1'b0;
          timeout_d  = kp_io.time_up;
        end else if (is_digit) begin
          buf_d   = shifted;
          count_d = count_inc;
          if (count_inc == CntLen) begin
            state_d    = StCheck;
            timer_en_d = 1'b0;
          end
        end
      end
      StCheck: begin
        hold_d = '0;
        if (buf_q == CODE[BufW-1:0]) begin
          state_d  = StUnlock;
          fails_d  = 3'd0;
          unlock_d = 1'b1;
        end else begin
          state_d = StFail;
          fails_d = fails_q + 3'd1;
          error_d = 1'b1;
        end
      end
      StUnlock: begin
        if (hold_q == HoldEnd) begin
          state_d  = StIdle;
          unlock_d = 1'b0;
          buf_d    = '0;
          count_d  = 3'd0;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      StFail: begin
        if (hold_q == HoldEnd) begin
          error_d = 1'b0;
          buf_d   = '0;
          count_d = 3'd0;
          hold_d  = '0;
          if (fails_q >= 3'(MAX_FAILS)) begin
            state_d   = StLockout;
            lockout_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      StLockout: begin
        if (hold_q == LockEnd) begin
          state_d   = StIdle;
          lockout_d = 1'b0;
          fails_d   = 3'd0;
          hold_d    = '0;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      count_q    <= 3'd0;
      fails_q    <= 3'd0;
      hold_q     <= '0;
      timer_en_q <= 1'b0;
      unlock_q   <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      fails_q    <= fails_d;
      hold_q     <= hold_d;
      timer_en_q <= timer_en_d;
      unlock_q   <= unlock_d;
      error_q    <= error_d;
      timeout_q  <= timeout_d;
      lockout_q  <= lockout_d;
    end
  end

  assign kp_io.timer_en    = timer_en_q;
  assign kp_io.unlock      = unlock_q;
  assign kp_io.error       = error_q;
  assign kp_io.timeout     = timeout_q;
  assign kp_io.lockout     = lockout_q;
  assign kp_io.digit_count = count_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Bench for keypad_code_entry: a vector table for key/timer handling plus
// scoreboarded code entries covering unlock, error, lockout and reset.
module tb_keypad_code_entry;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  keypad_code_entry_if kp();

  keypad_code_entry dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kp_io   (kp)
  );

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       tu;
    logic [2:0] cnt;
    logic       ten;
    logic       tmo;
  } vec_t;

  typedef struct {
    logic unl;
    logic err;
    logic lock;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(posedge clk); #1;
    kp.key_valid = 1'b1;
    kp.key_code  = k;
    @(posedge clk); #1;
    kp.key_valid = 1'b0;
    kp.key_code  = 4'h0;
  endtask

  task automatic enter_code(input logic [15:0] code, input exp_t e, input bit track);
    for (int i = 0; i < 4; i++) begin
      press(code[15-4*i -: 4]);
      chk("digit_count step", 32'(kp.digit_count), 32'(i + 1));
      chk("timer_en in entry", 32'(kp.timer_en), 32'(i < 3));
    end
    if (track) sb.push_back(e);
  endtask

  task automatic wait_result();
    exp_t e;
    int   n;
    int   d;
    e = sb.pop_front();
    n = 0;
    while (!(kp.unlock || kp.error) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("result latency", 32'(n), 32'd1);
    chk("unlock value", 32'(kp.unlock), 32'(e.unl));
    chk("error value", 32'(kp.error), 32'(e.err));
    d = 0;
    while ((kp.unlock || kp.error) && d < 5000) begin
      @(posedge clk); #1;
      d++;
    end
    chk("hold length", 32'(d), 32'd100);
    chk("lockout after hold", 32'(kp.lockout), 32'(e.lock));
    if (!e.lock) begin
      chk("timer_en after hold", 32'(kp.timer_en), 32'd0);
      chk("digit_count after hold", 32'(kp.digit_count), 32'd0);
    end
  endtask

  task automatic lockout_phase();
    int   l;
    logic seen;
    l    = 0;
    seen = 1'b0;
    while (kp.lockout && l < 5000) begin
      kp.key_valid = (l % 7 == 0);
      kp.key_code  = 4'h1;
      @(posedge clk); #1;
      seen = seen | kp.unlock | kp.error | kp.timer_en | (kp.digit_count != 3'd0);
      l++;
    end
    kp.key_valid = 1'b0;
    chk("lockout length", 32'(l), 32'd1000);
    chk("keys ignored in lockout", 32'(seen), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    kp.key_valid = 1'b0;
    kp.key_code  = 4'h0;
    kp.time_up   = 1'b0;

    vecs[0]  = '{1'b1, 4'hE, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'hB, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'h1, 1'b0, 3'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'hA, 1'b0, 3'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 1'b0, 3'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'h2, 1'b0, 3'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'hE, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'h1, 1'b0, 3'd1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'h2, 1'b0, 3'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'h0, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0};

    #2 reset_n = 1'b0;
    #20;
    chk("reset timer_en", 32'(kp.timer_en), 32'd0);
    chk("reset unlock", 32'(kp.unlock), 32'd0);
    chk("reset error", 32'(kp.error), 32'd0);
    chk("reset timeout", 32'(kp.timeout), 32'd0);
    chk("reset lockout", 32'(kp.lockout), 32'd0);
    chk("reset digit_count", 32'(kp.digit_count), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      kp.key_valid = vecs[i].kv;
      kp.key_code  = vecs[i].kc;
      kp.time_up   = vecs[i].tu;
      @(posedge clk); #1;
      chk($sformatf("vec%0d digit_count", i), 32'(kp.digit_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d timer_en", i), 32'(kp.timer_en), 32'(vecs[i].ten));
      chk($sformatf("vec%0d timeout", i), 32'(kp.timeout), 32'(vecs[i].tmo));
      chk($sformatf("vec%0d error", i), 32'(kp.error | kp.unlock), 32'd0);
    end
    kp.key_valid = 1'b0;
    kp.time_up   = 1'b0;

    // Correct, wrong, correct (clears fails), then three wrong to reach lockout.
    enter_code(16'h1234, '{1'b1, 1'b0, 1'b0}, 1'b1);
    wait_result();
    enter_code(16'h1235, '{1'b0, 1'b1, 1'b0}, 1'b1);
    wait_result();
    enter_code(16'h1234, '{1'b1, 1'b0, 1'b0}, 1'b1);
    wait_result();
    enter_code(16'h1235, '{1'b0, 1'b1, 1'b0}, 1'b1);
    wait_result();
    enter_code(16'h9999, '{1'b0, 1'b1, 1'b0}, 1'b1);
    wait_result();
    enter_code(16'h0000, '{1'b0, 1'b1, 1'b1}, 1'b1);
    wait_result();
    lockout_phase();
    chk("digit_count after lockout", 32'(kp.digit_count), 32'd0);
    enter_code(16'h4321, '{1'b0, 1'b1, 1'b0}, 1'b1);
    wait_result();
    enter_code(16'h1234, '{1'b1, 1'b0, 1'b0}, 1'b1);
    wait_result();

    // Last digit and time_up in the same cycle: timeout wins, no check.
    press(4'h1);
    press(4'h2);
    press(4'h3);
    chk("simul pre count", 32'(kp.digit_count), 32'd3);
    @(posedge clk); #1;
    kp.key_valid = 1'b1;
    kp.key_code  = 4'h4;
    kp.time_up   = 1'b1;
    @(posedge clk); #1;
    kp.key_valid = 1'b0;
    kp.time_up   = 1'b0;
    chk("simul timeout", 32'(kp.timeout), 32'd1);
    chk("simul digit_count", 32'(kp.digit_count), 32'd0);
    chk("simul timer_en", 32'(kp.timer_en), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | kp.unlock | kp.error | kp.timeout;
    end
    chk("simul no result", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of an unlock hold.
    enter_code(16'h1234, '{1'b1, 1'b0, 1'b0}, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("unlock before reset", 32'(kp.unlock), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async reset unlock", 32'(kp.unlock), 32'd0);
    chk("async reset digit_count", 32'(kp.digit_count), 32'd0);
    chk("async reset others",
        32'(kp.error | kp.lockout | kp.timeout | kp.timer_en), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    enter_code(16'h1234, '{1'b1, 1'b0, 1'b0}, 1'b1);
    wait_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
